// File: rtl/vga_color_ctrl_if.sv
// vga_color_ctrl_if: groups the button/frame inputs and colour outputs of vga_color_ctrl.
//   but_R/G/B    raw colour-increment buttons (async, active-high)
//   but_M        raw mode button (async, active-high)
//   frame_start  one-cycle vertical-blank pulse, synchronous to clk
//   out_R/G/B    registered 4-bit colour settings
//   auto_mode    registered mode flag (1 = auto cycling)
//   upd          registered one-cycle pulse after any colour change
// master = stimulus / consumer side, slave = the controller.
interface vga_color_ctrl_if;
    logic       but_R;
    logic       but_G;
    logic       but_B;
    logic       but_M;
    logic       frame_start;
    logic [3:0] out_R;
    logic [3:0] out_G;
    logic [3:0] out_B;
    logic       auto_mode;
    logic       upd;

    modport master (
        output but_R, but_G, but_B, but_M, frame_start,
        input  out_R, out_G, out_B, auto_mode, upd
    );

    modport slave (
        input  but_R, but_G, but_B, but_M, frame_start,
        output out_R, out_G, out_B, auto_mode, upd
    );
endinterface

// File: rtl/vga_color_ctrl.sv
// vga_color_ctrl: button-driven / auto-cycling colour register for a VGA pixel datapath.
//   clk  pixel clock
//   rst  asynchronous active-low reset
//   bus  vga_color_ctrl_if.slave (buttons, frame_start in; out_R/G/B, auto_mode, upd out)
// Buttons are synchronized and debounced; colour changes happen only on frame_start.
// Manual mode serves one pending channel per frame, round-robin R->G->B.
// Auto mode steps {R,G,B} as one 12-bit value every AUTO_FRAMES frames.
module vga_color_ctrl #(
    parameter logic [15:0] DEB_CNT     = 16'd50000,
    parameter logic [31:0] AUTO_FRAMES = 32'd60
) (
    input logic             clk,
    input logic             rst,
    vga_color_ctrl_if.slave bus
);

    // Button index: 0 = R, 1 = G, 2 = B, 3 = M.
    logic [3:0]  raw;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  deb_q, deb_d;
    logic [3:0]  deb_del_q, deb_del_d;
    logic [3:0]  arm_q, arm_d;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];
    logic [1:0]  settle_q, settle_d;
    logic        settled;
    logic [3:0]  rise;

    logic [2:0]  pend_q, pend_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  sel;
    logic [31:0] frm_q, frm_d;
    logic [11:0] rgb_q, rgb_d;
    logic        auto_q, auto_d;
    logic        upd_q, upd_d;

    assign raw = {bus.but_M, bus.but_B, bus.but_G, bus.but_R};

    // Synchronizer, debounce and edge detection.
    // A button is only armed once it has been seen released after the synchronizer
    // has filled following reset, so a button held through reset yields no edge.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_del_d = deb_q;
        settled   = (settle_q == 2'd2);
        settle_d  = settled ? settle_q : settle_q + 2'd1;
        arm_d     = arm_q | ({4{settled}} & ~sync2_q);
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = 16'd0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_CNT - 16'd1) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
        rise = deb_q & ~deb_del_q & arm_q;
    end

    // Round-robin pick starting after the last served channel.
    always_comb begin
        unique case (last_q)
            2'd0:    sel = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
            2'd1:    sel = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
            default: sel = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        last_d = last_q;
        frm_d  = frm_q;
        rgb_d  = rgb_q;
        auto_d = auto_q;
        if (rise[3]) begin
            // Mode toggle wins over any frame_start in the same cycle.
            auto_d = ~auto_q;
            frm_d  = 32'd0;
            pend_d = 3'b000;
        end else if (auto_q) begin
            pend_d = 3'b000;
            if (bus.frame_start) begin
                if (frm_q == AUTO_FRAMES - 32'd1) begin
                    frm_d = 32'd0;
                    rgb_d = rgb_q + 12'd1;
                end else begin
                    frm_d = frm_q + 32'd1;
                end
            end
        end else begin
            if (bus.frame_start && (pend_q != 3'b000)) begin
                last_d      = sel;
                pend_d[sel] = 1'b0;
                case (sel)
                    2'd0:    rgb_d[11:8] = rgb_q[11:8] + 4'd1;
                    2'd1:    rgb_d[7:4]  = rgb_q[7:4] + 4'd1;
                    default: rgb_d[3:0]  = rgb_q[3:0] + 4'd1;
                endcase
            end
            // OR-ing new edges last keeps a flag set when edge and service coincide.
            pend_d = pend_d | rise[2:0];
        end
        upd_d = (rgb_d != rgb_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 4'b0;
            sync2_q   <= 4'b0;
            deb_q     <= 4'b0;
            deb_del_q <= 4'b0;
            arm_q     <= 4'b0;
            cnt_q     <= '{default: '0};
            settle_q  <= 2'd0;
            pend_q    <= 3'b0;
            last_q    <= 2'd2;
            frm_q     <= 32'd0;
            rgb_q     <= 12'd0;
            auto_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_del_q <= deb_del_d;
            arm_q     <= arm_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            frm_q     <= frm_d;
            rgb_q     <= rgb_d;
            auto_q    <= auto_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.out_R     = rgb_q[11:8];
    assign bus.out_G     = rgb_q[7:4];
    assign bus.out_B     = rgb_q[3:0];
    assign bus.auto_mode = auto_q;
    assign bus.upd       = upd_q;

endmodule

// File: doc/vga_color_ctrl.md
VGA_COLOR_CTRL -- requirements
Module: vga_color_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 16'd50000: consecutive clk cycles a synchronized button must differ from its debounced level before that level flips.
REQ-002 Parameter AUTO_FRAMES, default 32'd60: frame_start pulses per auto-mode colour step.
REQ-003 Port clk  input  1  pixel clock; sole clock of the block.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Ports but_R, but_G, but_B  input  1 each  raw asynchronous colour-increment buttons, active-high.
REQ-006 Port but_M  input  1  raw asynchronous mode button, active-high.
REQ-007 Port frame_start  input  1  single-cycle pulse from the timing generator at vertical-blank start, synchronous to clk.
REQ-008 Ports out_R, out_G, out_B  output  4 each  registered colour settings driving the pixel datapath.
REQ-009 Port auto_mode  output  1  registered; 1 = auto colour cycling, 0 = button control.
REQ-010 Port upd  output  1  registered single-cycle pulse, high the cycle after any out_* change.

Function
REQ-011 Each of the four buttons SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each button SHALL have a debounce counter: it clears whenever the synchronized input equals the debounced level; otherwise it increments, and on reaching DEB_CNT the debounced level flips and the counter clears.
REQ-013 A 0->1 transition of a debounced colour level SHALL set that channel's pending flag; a further edge while pending is set SHALL be absorbed, giving one increment only.
REQ-014 Colour changes SHALL occur only on the clk edge that samples frame_start=1; out_* SHALL be stable at all other times.
REQ-015 Manual mode (auto_mode=0): on frame_start with any pending flag set, exactly one channel SHALL be served, chosen round-robin in R->G->B->R order starting after the last served channel.
REQ-016 Serving a channel SHALL increment its out_* modulo 16 (15 -> 0) and clear its pending flag.
REQ-017 Pending flags SHALL be evaluated from their registered values; an edge arriving in the frame_start cycle SHALL set pending but SHALL NOT be served until a later frame_start.
REQ-018 If a channel's edge and its own service coincide, the pending flag SHALL remain set.
REQ-019 Auto mode: a frame counter SHALL count frame_start pulses 0..AUTO_FRAMES-1; on the pulse where it equals AUTO_FRAMES-1 it SHALL wrap to 0 and {out_R,out_G,out_B} SHALL increment as one 12-bit value (out_B is LSB), 12'hFFF -> 12'h000.
REQ-020 In auto mode, colour-button edges SHALL be ignored and pending flags SHALL be held at 0.
REQ-021 A debounced but_M rising edge SHALL toggle auto_mode on the next clk edge, clear the frame counter and all pending flags, and leave out_* unchanged.
REQ-022 A but_M toggle coinciding with frame_start SHALL take priority: no colour change that cycle.
REQ-023 upd SHALL be 1 for exactly one cycle following each clk edge on which any out_* changed, else 0.

Reset
REQ-024 While rst=0: out_R/G/B=0, auto_mode=0, upd=0, pending flags=0, debounced levels=0, debounce and frame counters=0, synchronizers=0, round-robin pointer set so R has highest priority.
REQ-025 Reset assertion mid-debounce or mid-frame-count SHALL abandon all progress; no increment SHALL be generated on release.

Verification (DEB_CNT=4, AUTO_FRAMES=3)
REQ-026 Press but_R for 10 cycles, then frame_start -> out_R 0->1, upd high one cycle; a glitch of 3 cycles -> no change.
REQ-027 Press R, G and B before one frame_start, then three more frame_starts -> R=1 after frame 1, G=1 after frame 2, B=1 after frame 3; frame 4 -> no change, upd stays 0.
REQ-028 Sixteen debounced but_G presses, each served -> out_G wraps 15->0 at the 16th.
REQ-029 Toggle but_M, preload out={F,F,E}; frame_start x6 -> out becomes FFF after the 3rd pulse and 000 after the 6th; colour presses in this mode -> ignored.
REQ-030 Assert rst mid-press and with pending set -> all outputs 0; release with button held stable -> no spurious increment until the button is released and pressed again.
